bounce_emulator: RTL and testbench

- Transmitter-side model of a mechanical push-button, driven by a clean level request.
- When the requested level changes, the block drives a deterministic, pseudo-random bouncy waveform on `bounce_out`, then settles at the new level. It pulses `done` when the output is stable.
- Synthesizable so it can stimulate the debounce path both on-chip (self-test) and in simulation.

---
 rtl/bounce_emulator.sv | 142 ++++++++++++++
 tb/tb_bounce_emulator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bounce_emulator.sv
// rtl/bounce_emulator.sv - push-button model: turns a clean level change into an LFSR-timed bouncy waveform
module bounce_emulator #(
    parameter int         BOUNCES    = 3,
    parameter int         MAX_GLITCH = 4,
    parameter int         SETTLE     = 8,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic bounce_out,
    output logic busy,
    output logic done
);

    localparam int SEG_W = ((2 * BOUNCES + 1) > 1) ? $clog2(2 * BOUNCES + 1) : 1;
    localparam int CNT_W = ((MAX_GLITCH + 1) > 1) ? $clog2(MAX_GLITCH + 1) : 1;
    localparam int SET_W = ((SETTLE + 1) > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int LAST_SEG = (BOUNCES > 0) ? (2 * BOUNCES - 1) : 0;
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LEN_MASK = 8'(MAX_GLITCH - 1);
    localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BOUNCE,
        ST_SETTLE
    } state_t;

    state_t           state, state_nxt;
    logic             target, target_nxt;
    logic [7:0]       lfsr, lfsr_nxt;
    logic [SEG_W-1:0] seg_idx, seg_idx_nxt;
    logic [CNT_W-1:0] seg_cnt, seg_cnt_nxt;
    logic [SET_W-1:0] set_cnt, set_cnt_nxt;
    logic             bounce_nxt, busy_nxt, done_nxt;

    logic             start;
    logic             seg_end;
    logic             last_seg;
    logic             set_end;
    logic [7:0]       lfsr_step;
    logic [CNT_W-1:0] seg_len_m1;

    assign start      = (level_in != target);
    assign seg_end    = (seg_cnt == '0);
    assign last_seg   = (seg_idx == SEG_W'(LAST_SEG));
    assign set_end    = (set_cnt == '0);
    // x^8+x^6+x^5+x^4+1, shifting towards the MSB
    assign lfsr_step  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    // counters hold "cycles remaining minus one", so the length is loaded as len-1
    assign seg_len_m1 = CNT_W'(lfsr & LEN_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            target     <= 1'b0;
            lfsr       <= SEED_EFF;
            seg_idx    <= '0;
            seg_cnt    <= '0;
            set_cnt    <= '0;
            bounce_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            lfsr       <= lfsr_nxt;
            seg_idx    <= seg_idx_nxt;
            seg_cnt    <= seg_cnt_nxt;
            set_cnt    <= set_cnt_nxt;
            bounce_out <= bounce_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = (BOUNCES > 0) ? ST_BOUNCE : ST_SETTLE;
            ST_BOUNCE: if (seg_end && last_seg) state_nxt = ST_SETTLE;
            ST_SETTLE: if (set_end) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        target_nxt  = target;
        lfsr_nxt    = lfsr;
        seg_idx_nxt = seg_idx;
        seg_cnt_nxt = seg_cnt;
        set_cnt_nxt = set_cnt;
        bounce_nxt  = bounce_out;
        busy_nxt    = busy;
        done_nxt    = done;
        case (state)
            ST_IDLE: begin
                done_nxt   = 1'b0;
                bounce_nxt = target;
                if (start) begin
                    target_nxt = level_in;
                    bounce_nxt = level_in;
                    busy_nxt   = 1'b1;
                    if (BOUNCES > 0) begin
                        seg_idx_nxt = '0;
                        seg_cnt_nxt = seg_len_m1;
                        lfsr_nxt    = lfsr_step;
                    end else begin
                        set_cnt_nxt = SET_INIT;
                    end
                end
            end
            ST_BOUNCE: begin
                if (seg_end) begin
                    if (last_seg) begin
                        bounce_nxt  = target;
                        set_cnt_nxt = SET_INIT;
                    end else begin
                        // odd segments drive the inverse of the target
                        seg_idx_nxt = seg_idx + SEG_W'(1);
                        seg_cnt_nxt = seg_len_m1;
                        lfsr_nxt    = lfsr_step;
                        bounce_nxt  = target ^ ~seg_idx[0];
                    end
                end else begin
                    seg_cnt_nxt = seg_cnt - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (set_end) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                end else begin
                    set_cnt_nxt = set_cnt - SET_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bounce_emulator.sv
// tb/tb_bounce_emulator.sv - directed vector bench for bounce_emulator
module tb_bounce_emulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lvl_fix = 1'b0, lvl_rnd = 1'b0, lvl_zero = 1'b0;
    logic bo_fix, busy_fix, done_fix;
    logic bo_rnd, busy_rnd, done_rnd;
    logic bo_zero, busy_zero, done_zero;
    logic [2:0] o_fix, o_rnd, o_zero;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign o_fix  = {bo_fix, busy_fix, done_fix};
    assign o_rnd  = {bo_rnd, busy_rnd, done_rnd};
    assign o_zero = {bo_zero, busy_zero, done_zero};

    bounce_emulator #(.BOUNCES(3), .MAX_GLITCH(1), .SETTLE(8), .SEED(8'hA5)) u_fix (
        .clk(clk), .rst(rst), .level_in(lvl_fix),
        .bounce_out(bo_fix), .busy(busy_fix), .done(done_fix)
    );

    bounce_emulator #(.BOUNCES(3), .MAX_GLITCH(4), .SETTLE(8), .SEED(8'hA5)) u_rnd (
        .clk(clk), .rst(rst), .level_in(lvl_rnd),
        .bounce_out(bo_rnd), .busy(busy_rnd), .done(done_rnd)
    );

    bounce_emulator #(.BOUNCES(0), .MAX_GLITCH(4), .SETTLE(3), .SEED(8'hA5)) u_zero (
        .clk(clk), .rst(rst), .level_in(lvl_zero),
        .bounce_out(bo_zero), .busy(busy_zero), .done(done_zero)
    );

    typedef struct {
        logic       lvl;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[32];

    // expectation packing is {bounce_out, busy, done}
    task automatic chk(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%b want=%b", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int lens[6] = '{2, 3, 2, 3, 1, 2};

    initial begin
        // press (h=0) then release (h=1) on the fixed-length instance
        for (int h = 0; h < 2; h++) begin
            for (int j = 0; j < 16; j++) begin
                logic b, bs, d;
                b  = (j < 6) ? (j % 2 == 0) : 1'b1;
                bs = (j < 14);
                d  = (j == 14);
                tbl[h * 16 + j].lvl = (h == 0);
                tbl[h * 16 + j].exp = {b ^ (h == 1), bs, d};
            end
        end

        #1;
        chk("rst_fix", 0, o_fix, 3'b000);
        chk("rst_rnd", 0, o_rnd, 3'b000);
        chk("rst_zero", 0, o_zero, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_fix", 0, o_fix, 3'b000);

        for (int i = 0; i < 32; i++) begin
            lvl_fix = tbl[i].lvl;
            tick();
            chk("tbl", i, o_fix, tbl[i].exp);
        end

        // random segment lengths from SEED 8'hA5: 2,3,2,3,1,2 then 8 settle cycles
        lvl_rnd = 1'b1;
        for (int s = 0; s < 6; s++) begin
            for (int r = 0; r < lens[s]; r++) begin
                tick();
                chk("rnd_seg", s * 4 + r, o_rnd, {(s % 2 == 0), 1'b1, 1'b0});
            end
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rnd_settle", c, o_rnd, 3'b110);
        end
        tick();
        chk("rnd_done", 0, o_rnd, 3'b101);
        tick();
        chk("rnd_idle", 0, o_rnd, 3'b100);

        // no bounces, SETTLE=3
        lvl_zero = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("zero_settle", c, o_zero, 3'b110);
        end
        tick();
        chk("zero_done", 0, o_zero, 3'b101);
        tick();
        chk("zero_idle", 0, o_zero, 3'b100);

        // level toggles 1->0->1 while busy: sequence unchanged, no restart
        lvl_fix = 1'b1;
        tick();
        chk("busy_a", 0, o_fix, 3'b110);
        for (int k = 1; k < 6; k++) begin
            if (k == 2) lvl_fix = 1'b0;
            if (k == 4) lvl_fix = 1'b1;
            tick();
            chk("busy_a", k, o_fix, {(k % 2 == 0), 1'b1, 1'b0});
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("busy_a_settle", c, o_fix, 3'b110);
        end
        tick();
        chk("busy_a_done", 0, o_fix, 3'b101);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("busy_a_quiet", c, o_fix, 3'b100);
        end

        // release, then a change left pending restarts a press right after done
        lvl_fix = 1'b0;
        tick();
        chk("busy_b", 0, o_fix, 3'b010);
        for (int k = 1; k < 6; k++) begin
            if (k == 3) lvl_fix = 1'b1;
            tick();
            chk("busy_b", k, o_fix, {(k % 2 == 1), 1'b1, 1'b0});
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("busy_b_settle", c, o_fix, 3'b010);
        end
        tick();
        chk("busy_b_done", 0, o_fix, 3'b001);
        tick();
        chk("busy_b_restart", 0, o_fix, 3'b110);
        for (int c = 0; c < 16; c++) tick();
        chk("busy_b_final", 0, o_fix, 3'b100);

        // async reset mid-BOUNCE, then a fresh sequence whose first segment is 2 long
        lvl_fix  = 1'b0;
        lvl_zero = 1'b0;
        lvl_rnd  = 1'b0;
        tick();
        chk("ar_start", 0, o_rnd, 3'b010);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("ar_rnd", 0, o_rnd, 3'b000);
        chk("ar_fix", 0, o_fix, 3'b000);
        lvl_rnd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ar_seg0", 0, o_rnd, 3'b110);
        tick();
        chk("ar_seg0", 1, o_rnd, 3'b110);
        tick();
        chk("ar_seg1", 0, o_rnd, 3'b010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
